chargen_line: RTL

- Parametrised character-stream source feeding a downstream write FIFO over the active-low n_cs/n_wr strobe pair.
- Generates a printable-character sequence over a configurable range, in ascending, descending or RFC 864 rotating-line mode.
- Optionally inserts CR/LF after every LINELEN characters.
- Used as a link/FIFO exerciser, with a running transfer count for the host side.

---
 rtl/chargen_line_if.sv | 16 +
 rtl/chargen_line.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/chargen_line_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// chargen_line_if : strobe-style write link between chargen_line and a FIFO
// Revision: 1.0
// ---------------------------------------------------------------------------
interface chargen_line_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] port;
  logic             n_wr;
  logic             n_cs;

  modport master (output port, output n_wr, input n_cs);
  modport slave  (input port, input n_wr, output n_cs);
endinterface
`default_nettype wire

// File: rtl/chargen_line.sv
`default_nettype none
// ---------------------------------------------------------------------------
// chargen_line : printable-character stream source with optional CR/LF lines
// Revision: 1.0
// ---------------------------------------------------------------------------
module chargen_line #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned FIRSTCHAR = 32'h20,
  parameter int unsigned LASTCHAR  = 32'h7E,
  parameter int unsigned LINELEN   = 72,
  parameter int unsigned EOL_EN    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode,
  chargen_line_if.master     bus,
  output logic               line_done,
  output logic [31:0]        char_count
);

  localparam int unsigned    COL_W      = (LINELEN > 1) ? $clog2(LINELEN) : 1;
  localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(LINELEN - 1);
  localparam logic [WIDTH-1:0] C_FIRST  = WIDTH'(FIRSTCHAR);
  localparam logic [WIDTH-1:0] C_LAST   = WIDTH'(LASTCHAR);
  localparam logic [WIDTH-1:0] C_CR     = WIDTH'(32'h0D);
  localparam logic [WIDTH-1:0] C_LF     = WIDTH'(32'h0A);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CHAR = 2'd1,
    S_CR   = 2'd2,
    S_LF   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] line_start_q, line_start_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [1:0]       cur_mode_q, cur_mode_d;
  logic [31:0]      char_count_q, char_count_d;
  logic             line_done_q, line_done_d;

  logic             n_wr;
  logic             xfer;
  logic             desc;
  logic             rot;

  function automatic logic [WIDTH-1:0] inc_wrap(input logic [WIDTH-1:0] v);
    return (v == C_LAST) ? C_FIRST : v + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] dec_wrap(input logic [WIDTH-1:0] v);
    return (v == C_FIRST) ? C_LAST : v - WIDTH'(1);
  endfunction

  assign n_wr = (state_q == S_IDLE);
  assign xfer = ~n_wr & ~bus.n_cs;
  // Mode 11 falls through to ascending because only 01 and 10 are decoded.
  assign desc = (cur_mode_q == 2'b01);
  assign rot  = (cur_mode_q == 2'b10);

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    line_start_d = line_start_q;
    col_d        = col_q;
    cur_mode_d   = cur_mode_q;
    char_count_d = char_count_q;
    line_done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en) begin
          cur_mode_d = mode;
          cur_d      = (mode == 2'b01) ? C_LAST : line_start_q;
          col_d      = '0;
          state_d    = S_CHAR;
        end
      end
      S_CHAR: begin
        if (xfer) begin
          char_count_d = char_count_q + 32'd1;
          cur_d        = desc ? dec_wrap(cur_q) : inc_wrap(cur_q);
          col_d        = col_q + COL_W'(1);
          if (col_q == C_COL_LAST) begin
            col_d = '0;
            if (rot) begin
              line_start_d = inc_wrap(line_start_q);
              cur_d        = inc_wrap(line_start_q);
            end
            if (EOL_EN != 0) begin
              state_d = S_CR;
            end else begin
              line_done_d = 1'b1;
              state_d     = en ? S_CHAR : S_IDLE;
            end
          end
        end
      end
      S_CR: begin
        if (xfer) begin
          char_count_d = char_count_q + 32'd1;
          state_d      = S_LF;
        end
      end
      S_LF: begin
        if (xfer) begin
          char_count_d = char_count_q + 32'd1;
          line_done_d  = 1'b1;
          state_d      = en ? S_CHAR : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_q        <= C_FIRST;
      line_start_q <= C_FIRST;
      col_q        <= '0;
      cur_mode_q   <= 2'b00;
      char_count_q <= 32'd0;
      line_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      line_start_q <= line_start_d;
      col_q        <= col_d;
      cur_mode_q   <= cur_mode_d;
      char_count_q <= char_count_d;
      line_done_q  <= line_done_d;
    end
  end

  assign bus.n_wr   = n_wr;
  assign bus.port   = (state_q == S_CR) ? C_CR :
                      (state_q == S_LF) ? C_LF : cur_q;
  assign line_done  = line_done_q;
  assign char_count = char_count_q;

endmodule
`default_nettype wire
